// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 32x32 register file slice.
package regfile_pkg;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int RD_PORTS   = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_32x32_if.sv
// Write and dual read bus of the register file.
// master = requester (decode/execute side), slave = register file.
interface regfile_32x32_if;
  import regfile_pkg::*;

  logic      we;
  reg_addr_t waddr;
  reg_data_t wdata;
  logic      re1;
  reg_addr_t raddr1;
  logic      re2;
  reg_addr_t raddr2;
  reg_data_t rdata1;
  logic      rvalid1;
  reg_data_t rdata2;
  logic      rvalid2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rvalid1, rdata2, rvalid2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rvalid1, rdata2, rvalid2
  );
endinterface

// File: rtl/regfile_32x32_decoder_32.sv
// 5-to-32 one-hot write-enable decoder; all-zero when we is low.
module decoder_32
  import regfile_pkg::*;
(
  input  reg_addr_t           waddr,
  input  logic                we,
  output logic [REG_NUM-1:0]  wen
);
  // One bit per register, gated by the global write enable.
  always_comb begin
    wen        = '0;
    wen[waddr] = we;
  end
endmodule

// File: rtl/regfile_32x32.sv
// 32-entry x 32-bit register file, one write port, two registered read ports.
// Optional macro REGFILE_WR_BYPASS_EN: a read hitting the register written on
// the same edge returns the new data; otherwise it returns the old contents.
module regfile_32x32
  import regfile_pkg::*;
#(
  parameter bit        ZERO_REG  = 1'b1,
  parameter reg_data_t RESET_VAL = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  regfile_32x32_if.slave bus
);
  logic [REG_NUM-1:0]                   wen;
  logic [REG_NUM-1:0][REG_DATA_W-1:0]   regs;

  logic [RD_PORTS-1:0]                  re;
  logic [RD_PORTS-1:0][REG_ADDR_W-1:0]  raddr;
  logic [RD_PORTS-1:0][REG_DATA_W-1:0]  rdata_q;
  logic [RD_PORTS-1:0]                  rvalid_q;

  assign re    = {bus.re2, bus.re1};
  assign raddr = {bus.raddr2, bus.raddr1};

  assign bus.rdata1  = rdata_q[0];
  assign bus.rdata2  = rdata_q[1];
  assign bus.rvalid1 = rvalid_q[0];
  assign bus.rvalid2 = rvalid_q[1];

  decoder_32 u_dec (
    .waddr (bus.waddr),
    .we    (bus.we),
    .wen   (wen)
  );

  // Storage: each register captures wdata when its one-hot enable is set;
  // r0 stays at zero when hardwired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++)
        regs[i] <= (ZERO_REG && i == 0) ? '0 : RESET_VAL;
    end else begin
      for (int i = 0; i < REG_NUM; i++)
        if (wen[i] && !(ZERO_REG && i == 0)) regs[i] <= bus.wdata;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic      zero_hit;
    logic      byp;
    reg_data_t rd_nxt;

    assign zero_hit = ZERO_REG && (raddr[p] == '0);
`ifdef REGFILE_WR_BYPASS_EN
    assign byp = bus.we && (raddr[p] == bus.waddr);
`else
    assign byp = 1'b0;
`endif

    // Zero register wins over bypass; bypass wins over stored data.
    always_comb begin
      rd_nxt = regs[raddr[p]];
      if (byp)      rd_nxt = bus.wdata;
      if (zero_hit) rd_nxt = '0;
    end

    // Registered read: data holds when idle, valid pulses per accepted read.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q[p]  <= '0;
        rvalid_q[p] <= 1'b0;
      end else begin
        rvalid_q[p] <= re[p];
        if (re[p]) rdata_q[p] <= rd_nxt;
      end
    end
  end
endmodule

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- 32-entry x 32-bit general-purpose register file; the storage stage directly downstream of the 5-to-32 write-enable decoder.
- The decoder's one-hot enable vector selects which register captures write data.
- Two independent read ports with registered (synchronous) outputs and per-port valid flags feed the execute stage.
- Register 0 is optionally hardwired to zero (MIPS-style).

Parameters:
- ZERO_REG, 1, when 1 register 0 ignores writes and always reads as 0; when 0 it is an ordinary register.
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  write enable.
- waddr  input  5  write register index.
- wdata  input  32  write data.
- re1  input  1  read request, port 1.
- raddr1  input  5  read register index, port 1.
- re2  input  1  read request, port 2.
- raddr2  input  5  read register index, port 2.
- rdata1  output  32  registered read data, port 1.
- rvalid1  output  1  rdata1 updated by a read accepted on the previous edge.
- rdata2  output  32  registered read data, port 2.
- rvalid2  output  1  rdata2 updated by a read accepted on the previous edge.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - All 32 registers = RESET_VAL (register 0 = 0 when ZERO_REG=1).
  - rdata1 = rdata2 = 0; rvalid1 = rvalid2 = 0.
- Reset dominates: a write or read presented on the same edge that rst is low is dropped.
- Write path:
  - One-hot enable = decoder(waddr, we).
  - On a rising edge with rst=1 and we=1: reg[waddr] <= wdata.
  - With we=0 nothing changes.
  - With ZERO_REG=1 and waddr=0 the write is discarded.
- Read path, per port, latency 1:
  - On an edge with reX=1: rdataX <= reg[raddrX]; rvalidX <= 1.
  - On an edge with reX=0: rdataX holds its value; rvalidX <= 0.
  - rvalidX is a single-cycle pulse per accepted read; back-to-back reads keep it high.
- Both ports may read the same address on the same edge; both return the same value.
- Read-during-write to the same address on the same edge: behaviour is set by REGFILE_WR_BYPASS_EN (see Optional Feature).
- With ZERO_REG=1, raddrX=0 always returns 0, including under bypass.
- No handshake stalls: every request is accepted every cycle; there are no full or empty conditions.
- All registers are 32 bits; no arithmetic. Unknown address bits do not occur (the 5-bit index covers all 32 entries).

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: if we=1, reX=1 and raddrX==waddr on the same edge (and not the zero register under ZERO_REG=1), rdataX <= wdata (new data).
- Undefined: rdataX <= the pre-write register contents (old data); the new value is visible from the next read onward.
- The macro has no effect on the write path or on timing.

Decomposition:
- Shared package regfile_pkg:
  - REG_NUM=32, REG_ADDR_W=5, REG_DATA_W=32.
  - typedef reg_addr_t (logic [4:0]), reg_data_t (logic [31:0]).
- One sub-module instance: decoder_32 (waddr, we -> 32-bit one-hot write enable).
- The storage array, read registers and bypass compare live in the top.

Test Plan:
- Reset then read all 32 addresses on both ports -> rdata = 0, rvalid pulses exactly 1 cycle after each request.
- Write 32'hDEAD_BEEF to r5, then re1=1, raddr1=5 -> next cycle rdata1 = 32'hDEAD_BEEF, rvalid1 = 1.
- ZERO_REG=1: write 32'h1234_5678 to r0, then read r0 on both ports -> 0; ZERO_REG=0 -> 32'h1234_5678.
- r7 = 32'h0000_0011, then on the same edge write 32'h0000_0022 to r7 and read r7 -> 32'h22 with the macro defined, 32'h11 without; the following read returns 32'h22 in both builds.
- Both ports read r3 = 32'hA5A5_A5A5 simultaneously while re toggles 1,0,1 -> both rdata = 32'hA5A5_A5A5, rdata holds while re=0, rvalid follows 1,0,1 delayed by one cycle.
- Assert rst low mid-cycle with we=1 to r9 = 32'hFFFF_FFFF -> outputs clear immediately without a clock edge; after release, r9 reads 0.
